// File: rtl/brief_desc_packer_pkg.sv
// brief_desc_packer_pkg
//   Shared constants and types for the binary-descriptor path (sampler ->
//   packer -> Hamming matcher).
//   - DESC_W_DEF / PIX_W_DEF / CNT_W_DEF : default descriptor, pixel and
//     pair-count widths
//   - state_t    : packer FSM states
//   - pix_pair_t : one sampled intensity pair as it leaves the patch sampler
package brief_desc_packer_pkg;

  localparam int DESC_W_DEF = 128;
  localparam int PIX_W_DEF  = 8;
  localparam int CNT_W_DEF  = $clog2(DESC_W_DEF) + 1;

  // ACC: shift register filling. HOLD: a complete descriptor is parked
  // because the output slot is still occupied.
  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic [PIX_W_DEF-1:0] pix_a;
    logic [PIX_W_DEF-1:0] pix_b;
    logic                 last;
  } pix_pair_t;

endpackage

// File: rtl/brief_desc_packer_slot.sv
// desc_out_slot
//   One-entry valid/ready output register. The payload is opaque to this
//   module; the packer concatenates {short, [popcnt,] desc} into it.
//   clk, rst_n : clock, async active-low reset
//   clr        : sync clear of the valid flag only (payload is kept)
//   load, din  : capture din and raise valid next cycle
//   ready      : downstream accept; valid drops when nothing new is loaded
//   valid,dout : slot contents, held stable while valid & !ready
module desc_out_slot #(
  parameter int W = 129
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/brief_desc_packer.sv
// brief_desc_packer
//   Packs pixel-pair samples into DESC_W-bit binary descriptors
//   (bit k = pix_a > pix_b for pair k of the patch, LSB first).
//   A closed descriptor goes straight to the output slot when it is free,
//   otherwise it waits in the shift register (HOLD) and input is stalled.
//   Ports:
//     clk, rst_n                  clock, async active-low reset
//     clr                         sync clear of partial and pending descriptors
//     s_valid/s_ready             pair handshake
//     s_pix_a, s_pix_b, s_last    pair intensities, end-of-patch marker
//     m_valid/m_ready             descriptor handshake
//     m_desc, m_short             descriptor, closed-early flag
//     m_popcnt                    ones in m_desc (only with DESC_POPCNT_EN)
//   Build option: define DESC_POPCNT_EN to add the m_popcnt output.
module brief_desc_packer
  import brief_desc_packer_pkg::*;
#(
  parameter int DESC_W = DESC_W_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int CNT_W  = $clog2(DESC_W) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PIX_W-1:0]  s_pix_a,
  input  logic [PIX_W-1:0]  s_pix_b,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DESC_W-1:0] m_desc,
  output logic              m_short
`ifdef DESC_POPCNT_EN
  ,
  output logic [CNT_W-1:0]  m_popcnt
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DESC_W - 1);
  localparam int IDX_W = CNT_W - 1;
`ifdef DESC_POPCNT_EN
  localparam int PAY_W = DESC_W + 1 + CNT_W;
`else
  localparam int PAY_W = DESC_W + 1;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DESC_W-1:0] sr_q, sr_d, sr_nxt;
  logic              short_q, short_d;
  logic              init_q;
  logic              accept, pair_bit, close, early, slot_free, slot_load;
  logic [PAY_W-1:0]  slot_din, slot_dout;
`ifdef DESC_POPCNT_EN
  logic [CNT_W-1:0]  ones_q, ones_d, ones_nxt;
`endif

  assign accept    = s_valid & s_ready;
  assign pair_bit  = s_pix_a > s_pix_b;
  assign close     = accept & ((cnt_q == LAST_CNT) | s_last);
  assign early     = s_last & (cnt_q != LAST_CNT);
  assign slot_free = ~m_valid | m_ready;

  // A new descriptor starts from zero whenever cnt is 0, so bits above the
  // write pointer are always clean even after clr left stale data behind.
  always_comb begin
    sr_nxt = (cnt_q == '0) ? '0 : sr_q;
    sr_nxt[cnt_q[IDX_W-1:0]] = pair_bit;
  end

`ifdef DESC_POPCNT_EN
  assign ones_nxt = ((cnt_q == '0) ? '0 : ones_q) + CNT_W'(pair_bit);
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ACC;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_ACC;
    end else begin
      case (state_q)
        ST_ACC:  if (close && !slot_free)   state_d = ST_HOLD;
        ST_HOLD: if (m_valid && m_ready)    state_d = ST_ACC;
        default: state_d = ST_ACC;
      endcase
    end
  end

  // FSM: outputs. s_ready depends on flops only.
  always_comb begin
    s_ready   = init_q & (state_q == ST_ACC);
    slot_load = 1'b0;
`ifdef DESC_POPCNT_EN
    slot_din  = {short_q, ones_q, sr_q};
`else
    slot_din  = {short_q, sr_q};
`endif
    if (!clr) begin
      if (state_q == ST_ACC) begin
        slot_load = close & slot_free;
`ifdef DESC_POPCNT_EN
        slot_din  = {early, ones_nxt, sr_nxt};
`else
        slot_din  = {early, sr_nxt};
`endif
      end else begin
        slot_load = m_valid & m_ready;
      end
    end
  end

  // Datapath next state. Shift register contents survive clr; only the
  // pair count is dropped.
  always_comb begin
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    short_d = short_q;
`ifdef DESC_POPCNT_EN
    ones_d  = ones_q;
`endif
    if (clr) begin
      cnt_d = '0;
    end else if (accept) begin
      sr_d    = sr_nxt;
      short_d = early;
      cnt_d   = close ? '0 : cnt_q + CNT_W'(1);
`ifdef DESC_POPCNT_EN
      ones_d  = ones_nxt;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sr_q    <= '0;
      short_q <= 1'b0;
      init_q  <= 1'b0;
`ifdef DESC_POPCNT_EN
      ones_q  <= '0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      short_q <= short_d;
      init_q  <= 1'b1;
`ifdef DESC_POPCNT_EN
      ones_q  <= ones_d;
`endif
    end
  end

  desc_out_slot #(.W(PAY_W)) u_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .load  (slot_load),
    .din   (slot_din),
    .ready (m_ready),
    .valid (m_valid),
    .dout  (slot_dout)
  );

  assign m_desc  = slot_dout[DESC_W-1:0];
  assign m_short = slot_dout[PAY_W-1];
`ifdef DESC_POPCNT_EN
  assign m_popcnt = slot_dout[DESC_W +: CNT_W];
`endif

endmodule
